// File: rtl/acc_burst_ctrl.sv
// rtl/acc_burst_ctrl.sv - burst sequencer for the accumulator datapath
// Clears the accumulator, streams iLen beats into it, then presents the sum until consumed.
module acc_burst_ctrl #(
    parameter int BITWIDTH = 32,
    parameter int CNTW     = 16
) (
    input  logic                iClk,
    input  logic                iRst,
    input  logic                iStart,
    input  logic [CNTW-1:0]     iLen,
    input  logic                iValid,
    input  logic [BITWIDTH-1:0] iData,
    output logic                oReady,
    output logic                oAccEn,
    output logic                oAccClr,
    output logic [BITWIDTH-1:0] oAccData,
    input  logic [BITWIDTH:0]   iAccData,
    output logic                oValid,
    output logic [BITWIDTH:0]   oResult,
    input  logic                iReady,
    output logic                oBusy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        ACC  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            nextState;
    logic [CNTW-1:0]   cnt;
    logic [CNTW-1:0]   cntNext;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nextState;
            cnt   <= cntNext;
        end
    end

    always_comb begin
        nextState = state;
        cntNext   = cnt;
        oReady    = 1'b0;
        oAccEn    = 1'b0;
        oAccClr   = 1'b0;
        oAccData  = '0;
        oValid    = 1'b0;
        oResult   = '0;
        oBusy     = (state != IDLE);

        case (state)
            IDLE: begin
                if (iStart) begin
                    nextState = CLR;
                    cntNext   = iLen;
                end
            end
            CLR: begin
                oAccClr   = 1'b1;
                nextState = (cnt != '0) ? ACC : DONE;
            end
            ACC: begin
                oReady   = 1'b1;
                oAccEn   = iValid;
                oAccData = iData;
                if (iValid) begin
                    cntNext = cnt - CNTW'(1);
                    // The accumulator registers this final beat on the same edge that enters DONE.
                    if (cnt == CNTW'(1)) begin
                        nextState = DONE;
                    end
                end
            end
            DONE: begin
                oValid  = 1'b1;
                oResult = iAccData;
                if (iReady) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_acc_burst_ctrl.sv
// tb/tb_acc_burst_ctrl.sv - randomized self-checking bench for acc_burst_ctrl
module tb_acc_burst_ctrl;

    localparam int BW = 8;
    localparam int CW = 8;

    logic          iClk = 1'b0;
    logic          iRst;
    logic          iStart;
    logic [CW-1:0] iLen;
    logic          iValid;
    logic [BW-1:0] iData;
    logic          oReady;
    logic          oAccEn;
    logic          oAccClr;
    logic [BW-1:0] oAccData;
    logic [BW:0]   iAccData;
    logic          oValid;
    logic [BW:0]   oResult;
    logic          iReady;
    logic          oBusy;

    int checkCnt = 0;
    int errCnt   = 0;
    int enPulses = 0;
    int dataQ[$];

    logic [BW:0] accReg = 9'h1A5;

    always #5 iClk = ~iClk;

    acc_burst_ctrl #(.BITWIDTH(BW), .CNTW(CW)) dut (
        .iClk(iClk), .iRst(iRst), .iStart(iStart), .iLen(iLen),
        .iValid(iValid), .iData(iData), .oReady(oReady), .oAccEn(oAccEn),
        .oAccClr(oAccClr), .oAccData(oAccData), .iAccData(iAccData),
        .oValid(oValid), .oResult(oResult), .iReady(iReady), .oBusy(oBusy)
    );

    // Stand-in for the external accumulator instance.
    always_ff @(posedge iClk) begin
        if (oAccClr) accReg <= '0;
        else if (oAccEn) accReg <= accReg + {1'b0, oAccData};
    end
    assign iAccData = accReg;

    always_ff @(posedge iClk) begin
        if (oAccEn) enPulses <= enPulses + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check_eq({tag, ":ready"}, 32'(oReady), 0);
        check_eq({tag, ":en"}, 32'(oAccEn), 0);
        check_eq({tag, ":clr"}, 32'(oAccClr), 0);
        check_eq({tag, ":valid"}, 32'(oValid), 0);
        check_eq({tag, ":busy"}, 32'(oBusy), 0);
        check_eq({tag, ":accdata"}, 32'(oAccData), 0);
        check_eq({tag, ":result"}, 32'(oResult), 0);
    endtask

    // gap < 0 selects a random 0..3 idle cycles before each beat.
    task automatic run_burst(input string name, input int len, input int gap, input int rdyDelay);
        int expSum;
        int pulses0;
        int g;
        expSum = 0;
        @(negedge iClk);
        iStart = 1'b1; iLen = CW'(len); iValid = 1'b0; iReady = 1'($urandom);
        #1 check_eq({name, ":idle"}, 32'(oBusy), 0);
        pulses0 = enPulses;
        @(negedge iClk);
        iStart = 1'b0; iValid = 1'($urandom); iData = BW'($urandom);
        #1;
        check_eq({name, ":clr"}, 32'(oAccClr), 1);
        check_eq({name, ":clr_ready"}, 32'(oReady), 0);
        check_eq({name, ":clr_busy"}, 32'(oBusy), 1);
        for (int i = 0; i < len; i++) begin
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            for (int k = 0; k < g; k++) begin
                @(negedge iClk);
                iValid = 1'b0; iData = BW'($urandom); iStart = 1'($urandom);
                #1;
                check_eq({name, ":stall_ready"}, 32'(oReady), 1);
                check_eq({name, ":stall_en"}, 32'(oAccEn), 0);
            end
            @(negedge iClk);
            iValid = 1'b1; iData = BW'(dataQ[i]); iStart = 1'($urandom);
            #1;
            check_eq({name, ":beat_en"}, 32'(oAccEn), 1);
            check_eq({name, ":beat_data"}, 32'(oAccData), 32'(dataQ[i]));
            check_eq({name, ":beat_valid"}, 32'(oValid), 0);
            expSum += dataQ[i];
        end
        expSum = expSum % (1 << (BW + 1));
        for (int j = 0; j <= rdyDelay; j++) begin
            @(negedge iClk);
            iValid = 1'($urandom); iData = BW'($urandom);
            iReady = (j == rdyDelay);
            iStart = (j == rdyDelay) ? 1'b1 : 1'($urandom);
            #1;
            check_eq({name, ":done_valid"}, 32'(oValid), 1);
            check_eq({name, ":done_result"}, 32'(oResult), 32'(expSum));
            check_eq({name, ":done_en"}, 32'(oAccEn), 0);
            check_eq({name, ":done_busy"}, 32'(oBusy), 1);
        end
        @(negedge iClk);
        iStart = 1'b0; iValid = 1'b0; iReady = 1'($urandom);
        #1 check_zero_outputs({name, ":after"});
        @(negedge iClk);
        #1 check_eq({name, ":handoff_start_ignored"}, 32'(oBusy), 0);
        check_eq({name, ":en_pulses"}, 32'(enPulses - pulses0), 32'(len));
    endtask

    initial begin
        int n;
        iRst = 1'b1; iStart = 1'b0; iLen = '0; iValid = 1'b0; iData = '0; iReady = 1'b0;
        repeat (2) @(negedge iClk);
        #1 check_zero_outputs("reset");
        iRst = 1'b0;

        dataQ = '{1, 2, 3, 4};
        run_burst("len4", 4, 0, 0);
        dataQ = '{5, 7, 9};
        run_burst("gaps", 3, 2, 0);
        dataQ = '{};
        run_burst("len0", 0, 0, 1);
        dataQ = '{255, 255, 255};
        run_burst("max3", 3, 0, 0);
        dataQ = '{255, 255, 255, 255, 255};
        run_burst("wrap", 5, -1, 0);
        dataQ = '{11, 22};
        run_burst("backpressure", 2, 0, 5);

        // Abort two beats into a four-beat burst.
        @(negedge iClk);
        iStart = 1'b1; iLen = 8'd4;
        @(negedge iClk);
        iStart = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge iClk);
            iValid = 1'b1; iData = 8'd50;
        end
        @(negedge iClk);
        iRst = 1'b1; iValid = 1'b1; iData = 8'd9;
        @(negedge iClk);
        iRst = 1'b0; iValid = 1'b0;
        #1 check_zero_outputs("abort");
        dataQ = '{3, 4};
        run_burst("post_abort", 2, 0, 0);

        for (int r = 0; r < 25; r++) begin
            n = int'($urandom_range(0, 10));
            dataQ = '{};
            for (int i = 0; i < n; i++) dataQ.push_back(int'($urandom_range(0, 255)));
            run_burst($sformatf("rand%0d", r), n, -1, int'($urandom_range(0, 4)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCnt, errCnt);
        $finish;
    end

endmodule
